// File: rtl/matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// matrix_stream_loader
//
// Assembles a stream of DATA_W-bit words into one TOTAL_W-bit operand frame and
// pulses `load` for one cycle once the frame is complete, so a downstream wide
// register can capture `out` in a single clock.
//
// Word k of a frame is written to out[k*DATA_W : k*DATA_W+DATA_W-1]. Because
// `out` is declared [0:TOTAL_W-1], the first word ends up in the most
// significant position of the bus.
//
// A word flagged with in_sof while a frame is partly filled restarts the frame
// at index 0. The partial frame is dropped without a load, and the sticky
// frame_err flag is raised. frame_err stays set until rst.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous reset, active high, has priority over everything
//   in_data    : stream word (DATA_W bits)
//   in_valid   : in_data is valid
//   in_sof     : first word of a frame (qualified by in_valid)
//   in_ready   : a word is accepted this cycle if in_valid is also high
//   out        : assembled frame [0:TOTAL_W-1]; connects to the wide register input
//   load       : one-cycle strobe; connects to the wide register load input
//   word_cnt   : index of the next word to be written
//   frame_err  : sticky resynchronisation error flag
// -----------------------------------------------------------------------------
module matrix_stream_loader #(
  parameter  int DATA_W  = 32,
  parameter  int TOTAL_W = 262144,               // must be a multiple of DATA_W
  localparam int NWORDS  = TOTAL_W / DATA_W,
  localparam int CNT_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic               in_ready,
  output logic [0:TOTAL_W-1] out,
  output logic               load,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               frame_err
);

  typedef enum logic {
    ST_FILL = 1'b0,   // accepting words
    ST_LOAD = 1'b1    // frame complete, strobe load for one cycle
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_ready;
  logic               w_load;
  logic               w_accept;
  logic               w_resync;
  logic               w_last;
  logic [CNT_W-1:0]   w_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [0:TOTAL_W-1] r_out;

  // Reset must win over a word presented in the same cycle, so the handshake
  // outputs are gated by rst. Neither depends on in_valid.
  assign in_ready = w_ready & ~rst;
  assign load     = w_load  & ~rst;
  assign w_accept = in_valid & in_ready;

  // A start-of-frame mid-frame restarts at index 0. At index 0, in_sof is
  // irrelevant: an unflagged first word is also a legal frame start.
  assign w_resync = in_sof & (r_cnt != '0);
  assign w_idx    = w_resync ? '0 : r_cnt;
  assign w_last   = (w_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of always_ff evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment before the case keeps this block purely
  // combinational; without it a missed branch would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_FILL: if (w_accept && w_last) w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_FILL;
      default: w_next_state = ST_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (functions of state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b0;
    w_load  = 1'b0;
    unique case (r_state)
      ST_FILL: w_ready = 1'b1;
      ST_LOAD: w_load  = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: frame buffer, word counter, sticky error
  // ---------------------------------------------------------------------------
  // NOTE: the frame buffer is reset to zeros on purpose, because the
  // downstream register must never capture undefined bits. This is a flop
  // array, not a RAM, so a reset is legal here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      // The decoder uses constant slice bases, so only the addressed word
      // changes. Bits not yet rewritten keep the previous frame's values.
      for (int k = 0; k < NWORDS; k++) begin
        if (w_idx == CNT_W'(k)) r_out[k*DATA_W +: DATA_W] <= in_data;
      end
      r_cnt <= w_last ? '0 : w_idx + 1'b1;
      if (w_resync) r_err <= 1'b1;
    end
  end

  assign out       = r_out;
  assign word_cnt  = r_cnt;
  assign frame_err = r_err;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_stream_loader
//
// Testbench for matrix_stream_loader with DATA_W=8 and TOTAL_W=32, so a frame
// is 4 words. Inputs are driven just after the falling edge. Outputs are
// sampled 1 ns later, well before the next rising edge.
//
// A frame-level reference model holds the 4 frame bytes, the fill position,
// the sticky error and a pending-load flag. It is updated once per rising edge
// from the handshake rules. Each scenario task also checks the literal values
// its scenario must produce.
// -----------------------------------------------------------------------------
module tb_matrix_stream_loader;

  localparam int DATA_W  = 8;
  localparam int TOTAL_W = 32;
  localparam int NWORDS  = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_sof;
  logic               in_ready;
  logic [0:TOTAL_W-1] out_bus;
  logic               load;
  logic [CNT_W-1:0]   word_cnt;
  logic               frame_err;

  matrix_stream_loader #(
    .DATA_W  (DATA_W),
    .TOTAL_W (TOTAL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out       (out_bus),
    .load      (load),
    .word_cnt  (word_cnt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Downstream wide register fed by out/load.
  logic [0:TOTAL_W-1] wide_reg;
  always @(posedge clk) if (load) wide_reg <= out_bus;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dut_loads = 0;
  int load_cycs[$];

  // Reference model
  logic [7:0] m_words [NWORDS];
  int         m_cnt   = 0;
  bit         m_err   = 1'b0;
  bit         m_load  = 1'b0;
  bit         m_known = 1'b0;

  // Snapshot of DUT outputs taken in the current cycle
  logic        obs_ready, obs_load, obs_err;
  logic [31:0] obs_out;
  logic [1:0]  obs_cnt;
  logic [31:0] last_load_out;

  function automatic logic [31:0] m_frame();
    logic [31:0] f = '0;
    for (int k = 0; k < NWORDS; k++) f = (f << 8) | 32'(m_words[k]);
    return f;
  endfunction

  // Drives one clock cycle, compares the DUT outputs with the model, then
  // advances the model across the rising edge.
  task automatic tick(input logic r, input logic v, input logic s, input logic [7:0] d);
    logic        exp_ready, exp_load;
    logic [1:0]  exp_cnt;
    logic [31:0] exp_out;
    bit          acc;
    rst = r; in_valid = v; in_sof = s; in_data = d;
    #1;
    obs_ready = in_ready; obs_load = load; obs_out = out_bus;
    obs_cnt = word_cnt; obs_err = frame_err;
    exp_ready = !r && !m_load;
    exp_load  = !r && m_load;
    exp_cnt   = m_cnt[1:0];
    exp_out   = m_frame();
    if (r || m_known) begin
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL in_ready cyc=%0d: got %b expected %b", cyc, obs_ready, exp_ready);
      end
      checks++;
      if (obs_load !== exp_load) begin
        errors++;
        $display("FAIL load cyc=%0d: got %b expected %b", cyc, obs_load, exp_load);
      end
    end
    if (m_known) begin
      checks++;
      if (obs_out !== exp_out) begin
        errors++;
        $display("FAIL out cyc=%0d: got %h expected %h", cyc, obs_out, exp_out);
      end
      checks++;
      if (obs_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL word_cnt cyc=%0d: got %0d expected %0d", cyc, obs_cnt, exp_cnt);
      end
      checks++;
      if (obs_err !== m_err) begin
        errors++;
        $display("FAIL frame_err cyc=%0d: got %b expected %b", cyc, obs_err, m_err);
      end
    end
    if (obs_load === 1'b1) begin
      dut_loads++;
      load_cycs.push_back(cyc);
      last_load_out = obs_out;
    end
    @(posedge clk);
    if (r) begin
      m_known = 1'b1; m_cnt = 0; m_err = 1'b0; m_load = 1'b0;
      for (int k = 0; k < NWORDS; k++) m_words[k] = 8'h00;
    end else if (m_known) begin
      acc    = v && !m_load;
      m_load = 1'b0;
      if (acc) begin
        if (s && m_cnt != 0) begin
          m_err = 1'b1; m_words[0] = d; m_cnt = 1;
        end else begin
          m_words[m_cnt] = d;
          if (m_cnt == NWORDS - 1) begin
            m_cnt = 0; m_load = 1'b1;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 8'hEE);
    tick(1'b1, 1'b1, 1'b0, 8'hEF);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_out !== 32'h0) begin
      errors++; $display("FAIL reset_out: got %h expected 00000000", obs_out);
    end
    checks++;
    if (obs_cnt !== 2'd0 || obs_err !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_err: got cnt=%0d err=%b expected 0/0", obs_cnt, obs_err);
    end
    checks++;
    if (obs_ready !== 1'b1 || obs_load !== 1'b0) begin
      errors++; $display("FAIL reset_ready_load: got %b/%b expected 1/0", obs_ready, obs_load);
    end
  endtask

  task automatic test_clean_frame();
    int l0 = dut_loads;
    tick(1'b0, 1'b1, 1'b1, 8'hA1);
    tick(1'b0, 1'b1, 1'b0, 8'hB2);
    tick(1'b0, 1'b1, 1'b0, 8'hC3);
    tick(1'b0, 1'b1, 1'b0, 8'hD4);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_load !== 1'b1 || obs_ready !== 1'b0 || obs_cnt !== 2'd0) begin
      errors++;
      $display("FAIL clean_load_cycle: got load=%b ready=%b cnt=%0d expected 1/0/0", obs_load, obs_ready, obs_cnt);
    end
    checks++;
    if (obs_out !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL clean_out: got %h expected a1b2c3d4", obs_out);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (dut_loads - l0 != 1 || obs_load !== 1'b0) begin
      errors++; $display("FAIL clean_load_count: got %0d expected 1", dut_loads - l0);
    end
    checks++;
    if (wide_reg !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL clean_wide_reg: got %h expected a1b2c3d4", wide_reg);
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] w [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int l0 = dut_loads;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, (i == 0), w[i]);
      checks++;
      if (obs_cnt !== 2'(i)) begin
        errors++; $display("FAIL bubble_cnt word %0d: got %0d expected %0d", i, obs_cnt, i);
      end
      for (int b = 0; b < 2; b++) begin
        tick(1'b0, 1'b0, 1'b0, 8'h5A);
        if (i == 3 && b == 0) begin
          checks++;
          if (obs_load !== 1'b1 || obs_out !== 32'hA1B2C3D4 || obs_cnt !== 2'd0) begin
            errors++;
            $display("FAIL bubble_load: got load=%b out=%h cnt=%0d expected 1/a1b2c3d4/0", obs_load, obs_out, obs_cnt);
          end
        end
      end
    end
    checks++;
    if (dut_loads - l0 != 1) begin
      errors++; $display("FAIL bubble_load_count: got %0d expected 1", dut_loads - l0);
    end
  endtask

  task automatic test_resync();
    int l0 = dut_loads;
    tick(1'b0, 1'b1, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 1'b0, 8'h22);
    tick(1'b0, 1'b1, 1'b1, 8'h33);
    tick(1'b0, 1'b1, 1'b0, 8'h44);
    checks++;
    if (obs_err !== 1'b1 || obs_cnt !== 2'd1) begin
      errors++; $display("FAIL resync_err: got err=%b cnt=%0d expected 1/1", obs_err, obs_cnt);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h55);
    tick(1'b0, 1'b1, 1'b0, 8'h66);
    checks++;
    if (dut_loads != l0) begin
      errors++; $display("FAIL resync_no_early_load: got %0d expected 0", dut_loads - l0);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_load !== 1'b1 || obs_out !== 32'h33445566 || obs_err !== 1'b1) begin
      errors++;
      $display("FAIL resync_load: got load=%b out=%h err=%b expected 1/33445566/1", obs_load, obs_out, obs_err);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_frame();
    int l0;
    tick(1'b0, 1'b1, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 1'b0, 8'h02);
    l0 = dut_loads;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b1, 8'h0A);
    tick(1'b0, 1'b1, 1'b0, 8'h0B);
    tick(1'b0, 1'b1, 1'b0, 8'h0C);
    tick(1'b0, 1'b1, 1'b0, 8'h0D);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_load !== 1'b1 || obs_out !== 32'h0A0B0C0D || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_load: got load=%b out=%h err=%b expected 1/0a0b0c0d/0", obs_load, obs_out, obs_err);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (dut_loads - l0 != 1) begin
      errors++; $display("FAIL midreset_load_count: got %0d expected 1", dut_loads - l0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  w [8];
    logic [31:0] exp2;
    int i = 0;
    int ready_low = 0;
    for (int k = 0; k < 8; k++) w[k] = 8'($urandom_range(255));
    exp2 = {w[4], w[5], w[6], w[7]};
    load_cycs.delete();
    for (int n = 0; n < 20 && i < 8; n++) begin
      tick(1'b0, 1'b1, (i % 4 == 0), w[i]);
      if (obs_ready !== 1'b1) ready_low++;
      if (obs_ready === 1'b1) i++;
    end
    checks++;
    if (i != 8) begin
      errors++; $display("FAIL b2b_timeout: got %0d words accepted expected 8", i);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    if (obs_ready !== 1'b1) ready_low++;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (load_cycs.size() != 2) begin
      errors++; $display("FAIL b2b_load_count: got %0d expected 2", load_cycs.size());
    end else begin
      checks++;
      if (load_cycs[1] - load_cycs[0] != 5) begin
        errors++; $display("FAIL b2b_load_spacing: got %0d expected 5", load_cycs[1] - load_cycs[0]);
      end
    end
    checks++;
    if (ready_low != 2) begin
      errors++; $display("FAIL b2b_ready_low: got %0d expected 2", ready_low);
    end
    checks++;
    if (last_load_out !== exp2) begin
      errors++; $display("FAIL b2b_second_frame: got %h expected %h", last_load_out, exp2);
    end
    checks++;
    if (wide_reg !== exp2) begin
      errors++; $display("FAIL b2b_wide_reg: got %h expected %h", wide_reg, exp2);
    end
  endtask

  // Ten cycles without load: only a partial frame is offered, so the
  // downstream register must keep the frame captured earlier.
  task automatic test_integration();
    logic [31:0] held;
    held = {m_words[0], m_words[1], m_words[2], m_words[3]};
    for (int n = 0; n < 10; n++) begin
      tick(1'b0, (n == 3 || n == 6), 1'b0, 8'($urandom_range(255)));
      checks++;
      if (obs_load !== 1'b0 || wide_reg !== held) begin
        errors++;
        $display("FAIL integ_hold cyc=%0d: got load=%b reg=%h expected 0/%h", cyc, obs_load, wide_reg, held);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(99) < 2), ($urandom_range(99) < 70),
           ($urandom_range(99) < 15), 8'($urandom_range(255)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_frame();
    test_bubbles();
    test_resync();
    test_reset_mid_frame();
    test_back_to_back();
    test_integration();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_stream_loader.md
MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of one input stream word.
REQ-002 The block SHALL have parameter TOTAL_W, default 262144: width of the assembled operand bus; TOTAL_W SHALL be a multiple of DATA_W.
REQ-003 The block SHALL have derived parameter NWORDS = TOTAL_W/DATA_W (default 8192) and CNT_W = clog2(NWORDS) (default 13).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port in_data, input, DATA_W bits: stream word.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_sof, input, 1 bit: the current word is the first word of a frame; qualified by in_valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-010 The block SHALL have port out, output, [0:TOTAL_W-1]: assembled frame; it drives the in port of the downstream wide register.
REQ-011 The block SHALL have port load, output, 1 bit: a one-cycle strobe that drives the load port of the downstream wide register.
REQ-012 The block SHALL have port word_cnt, output, CNT_W bits: index of the next word to be written.
REQ-013 The block SHALL have port frame_err, output, 1 bit: sticky resync error flag.

Function
REQ-014 A word SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; no other input is consumed.
REQ-015 The accepted word k (k = word_cnt) SHALL be written to out[k*DATA_W : k*DATA_W+DATA_W-1], so the first word lands in out[0:DATA_W-1] (MSB-first, ascending bit index).
REQ-016 The FSM SHALL have two states: FILL (in_ready=1, load=0) and LOAD (in_ready=0, load=1).
REQ-017 In FILL, an accepted word with word_cnt < NWORDS-1 SHALL increment word_cnt by 1.
REQ-018 In FILL, an accepted word with word_cnt = NWORDS-1 SHALL be written, set word_cnt to 0, and transition to LOAD.
REQ-019 LOAD SHALL last exactly one cycle, then transition to FILL; load is therefore high one cycle after the last word is accepted.
REQ-020 out SHALL hold the complete frame during the LOAD cycle and SHALL NOT change in that cycle.
REQ-021 out bits not yet overwritten by the next frame SHALL retain the previous frame's values.
REQ-022 The in_sof handling SHALL be as follows.
- Accepted word with in_sof=1 and word_cnt=0: normal first word.
- Accepted word with in_sof=1 and word_cnt≠0: the word is written at index 0, word_cnt becomes 1, and frame_err is set to 1.
- The partial frame is discarded and no load is issued for it.
REQ-023 An accepted word with in_sof=0 and word_cnt=0 SHALL be treated as a first word; this is not an error.
REQ-024 When NWORDS=1, every accepted word SHALL go directly to LOAD (REQ-018 precedence).
REQ-025 frame_err SHALL remain 1 until rst; no other event clears it.
REQ-026 in_ready SHALL be a registered function of state only and SHALL NOT depend combinationally on in_valid.
REQ-027 in_valid=0 cycles (bubbles) inside a frame SHALL leave word_cnt, out and state unchanged.

Reset
REQ-028 While rst=1 at a rising edge, the next state SHALL be as follows.
- state=FILL, word_cnt=0, load=0, frame_err=0, out=all zeros.
- in_ready=0 in any cycle where rst is high.
REQ-029 Reset SHALL have priority over every other event, including a word presented in the same cycle; that word SHALL NOT be accepted.
REQ-030 Reset asserted mid-frame or during LOAD SHALL discard the partial frame, and no load pulse SHALL follow.

Verification (bench parameters DATA_W=8, TOTAL_W=32, NWORDS=4)
REQ-031 The bench SHALL cover a clean frame: rst released, then words 0xA1,0xB2,0xC3,0xD4 back-to-back with in_sof on the first -> load=1 in the cycle after 0xD4, out=0xA1B2C3D4, in_ready=0 in that cycle, word_cnt=0.
REQ-032 The bench SHALL cover bubbles: the same words with in_valid low for 2 cycles between each -> same out, load exactly one cycle, word_cnt steps 0,1,2,3,0.
REQ-033 The bench SHALL cover resync: 0x11,0x22 followed by 0x33 with in_sof=1, then 0x44,0x55,0x66 -> no load after the first two words, frame_err=1, load after 0x66 with out=0x33445566.
REQ-034 The bench SHALL cover reset mid-frame: 0x01,0x02 followed by rst for one cycle, then 0x0A,0x0B,0x0C,0x0D -> out=0x0A0B0C0D, exactly one load pulse, frame_err=0.
REQ-035 The bench SHALL cover back-to-back frames: 8 words offered continuously with in_valid=1 -> in_ready drops only in the LOAD cycle, two load pulses 5 cycles apart, and the second out equals words 5..8.
REQ-036 The bench SHALL cover integration: out and load connected to the downstream wide register with load=0 for 10 cycles -> the register contents are unchanged.
